calc_result_fnd_driver: RTL
===========================

Name: calc_result_fnd_driver

Overview:
- Consumer end of the calculator result path: captures a binary result on a valid strobe and converts it to BCD sequentially (double-dabble, one shift per clock).
- Time-multiplexes the four BCD digits onto the 4-digit common-anode FND (active-low digit select and segments).
- Sits between the calculator datapath and the board FND pins.

Parameters:
- DATA_W, 8, result width in bits; legal range 4..13 (max 8191 fits in 4 digits).
- REFRESH_DIV, 100000, clocks per digit slot (1 kHz digit rate at 100 MHz); minimum 2.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_result  input  DATA_W  unsigned binary result to display.
- i_valid  input  1  one-cycle strobe; i_result sampled when accepted.
- o_busy  output  1  high while a conversion is in progress.
- o_done  output  1  one-cycle pulse when new digits reach the display register.
- o_fndCom  output  4  digit select, active-low one-hot; bit0 = ones digit.
- o_fndFont  output  8  segments {dp,g,f,e,d,c,b,a}, active-low; dp always 1 (off).

Behaviour:
- Reset state: o_busy=0, o_done=0, o_fndCom=4'b1111, o_fndFont=8'hFF. FSM=IDLE, digit index=0, refresh counter=0, shift/BCD registers=0, display register=0.
- Clock, reset and polarity: one clock domain, i_clk. i_reset is synchronous and active-high. All outputs are registered.
- Conversion FSM has three states:
  - IDLE: i_valid=1 latches i_result into the shift register, clears the 16-bit BCD accumulator and the shift counter, moves to SHIFT; o_busy goes 1 on the next edge.
  - SHIFT: each cycle, add 3 to every BCD nibble >=5, then shift {bcd,shift} left by 1. After DATA_W shifts, move to DONE.
  - DONE: for one cycle, copy BCD to the display register, pulse o_done=1, drop o_busy, return to IDLE.
- Latency: i_valid at edge N gives o_done=1 and an updated display register at edge N+DATA_W+1 (edge 9 for DATA_W=8).
- i_valid while in SHIFT or DONE is ignored; there is no queueing. i_valid is accepted again in the first IDLE cycle.
- The display register keeps the previous value during a conversion, so the display does not flicker.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the digit index increments modulo 4 (3 wraps to 0).
  - o_fndCom per index: 0 gives 1110, 1 gives 1101, 2 gives 1011, 3 gives 0111.
  - o_fndFont is the code of the selected display nibble, updated on the same edge as o_fndCom.
  - Scan starts on the first edge after reset release.
- Font codes (hex): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Any nibble >9 (unreachable) gives FF.
- Reset mid-conversion: the conversion is aborted, the FSM returns to IDLE, the display register clears to 0, and no o_done pulse is produced.
- i_reset and i_valid asserted together: reset wins and the value is not latched.

Optional Feature:
- Macro: FND_LEADING_ZERO_BLANK_EN.
- Defined: each leading zero digit above the most significant nonzero digit outputs FF (blank). The ones digit is never blanked, so value 0 shows as "   0".
- Undefined: all four digits are always shown, with zero padding ("0123").

Test Plan:
- Reset check, REFRESH_DIV=4: hold i_reset 3 cycles → o_fndCom=1111 and o_fndFont=FF during reset. Then the first edge after release gives 1110/C0, and digit select rotates 1101, 1011, 0111 every 4 clocks.
- Value 123, DATA_W=8: i_valid with i_result=8'd123 → o_busy high cycles 1-8, o_done pulse at cycle 9. Scan shows ones=B0, tens=A4, hundreds=F9. Thousands=C0 without the macro, FF with it.
- Value 255: o_fndFont per digit 92, 92, A4, then thousands C0 or FF depending on the macro; exactly one o_done pulse.
- Ignore while busy: i_valid with 45, then i_valid with 200 three cycles later → display shows 45 (99/92). A third i_valid with 200 after o_done → display 200 (C0, C0, A4).
- Reset mid-conversion: i_valid with 99, i_reset at cycle 4 → no o_done, o_busy=0, display shows 0 (C0 on ones).
- Accept after DONE: i_valid held high continuously with 7 → o_done pulses every DATA_W+2 cycles, display is stable at F8 on the ones digit.

Source files
------------

// File: rtl/calc_result_fnd_driver.sv
// calc_result_fnd_driver
// Purpose : captures a binary result on i_valid, converts it to BCD with a
//           sequential double-dabble (one shift per clock) and scans the four
//           digits onto a common-anode 4-digit FND (active-low select/segments).
// Ports   : i_clk, i_reset (sync, active-high), i_result/i_valid (input strobe),
//           o_busy (conversion running), o_done (display updated pulse),
//           o_fndCom (digit select, bit0 = ones), o_fndFont ({dp,g..a}, dp off).
// Option  : define FND_LEADING_ZERO_BLANK_EN to blank leading zero digits
//           (the ones digit is never blanked). Default shows zero padding.
module calc_result_fnd_driver #(
  parameter int DATA_W      = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_result,
  input  logic              i_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic [3:0]        o_fndCom,
  output logic [7:0]        o_fndFont
);

  localparam int WORK_W   = 16 + DATA_W;
  localparam int SH_CNT_W = $clog2(DATA_W + 1);
  localparam int CNT_W    = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  // {bcd[15:0], shift[DATA_W-1:0]} kept as one word so a single shift
  // moves the binary MSB into the BCD LSB.
  logic [WORK_W-1:0]   r_work, w_work_nxt, w_work_adj;
  logic [SH_CNT_W-1:0] r_shift_cnt, w_shift_cnt_nxt;
  logic [15:0]         r_disp, w_disp_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;

  logic [CNT_W-1:0]    r_refresh_cnt;
  logic [1:0]          r_digit_idx;
  logic [3:0]          r_fnd_com;
  logic [7:0]          r_fnd_font;
  logic [3:0]          w_nibble;
  logic [7:0]          w_font;

  function automatic logic [7:0] seg_code(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    w_work_adj = r_work;
    for (int i = 0; i < 4; i++) begin
      if (r_work[DATA_W + 4*i +: 4] >= 4'd5)
        w_work_adj[DATA_W + 4*i +: 4] = r_work[DATA_W + 4*i +: 4] + 4'd3;
    end
  end

  // Conversion FSM next-state / next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_work_nxt      = r_work;
    w_shift_cnt_nxt = r_shift_cnt;
    w_disp_nxt      = r_disp;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_valid) begin
          w_work_nxt      = {16'd0, i_result};
          w_shift_cnt_nxt = '0;
          w_busy_nxt      = 1'b1;
          w_state_nxt     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_work_nxt      = w_work_adj << 1;
        w_shift_cnt_nxt = r_shift_cnt + 1'b1;
        if (r_shift_cnt == SH_CNT_W'(DATA_W - 1))
          w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_disp_nxt  = r_work[DATA_W +: 16];
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_work      <= '0;
      r_shift_cnt <= '0;
      r_disp      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_work      <= w_work_nxt;
      r_shift_cnt <= w_shift_cnt_nxt;
      r_disp      <= w_disp_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Segment code for the digit currently indexed.
  assign w_nibble = r_disp[{r_digit_idx, 2'b00} +: 4];

  always_comb begin
    w_font = seg_code(w_nibble);
`ifdef FND_LEADING_ZERO_BLANK_EN
    // Blank a digit when it and every digit above it are zero.
    case (r_digit_idx)
      2'd1:    if (r_disp[15:4]  == 12'd0) w_font = 8'hFF;
      2'd2:    if (r_disp[15:8]  == 8'd0)  w_font = 8'hFF;
      2'd3:    if (r_disp[15:12] == 4'd0)  w_font = 8'hFF;
      default: w_font = seg_code(w_nibble);
    endcase
`endif
  end

  // Scan: select and font are registered from the current index, so the
  // first edge after reset shows digit 0.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= 2'd0;
      r_fnd_com     <= 4'b1111;
      r_fnd_font    <= 8'hFF;
    end else begin
      if (r_refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
        r_refresh_cnt <= '0;
        r_digit_idx   <= r_digit_idx + 2'd1;
      end else begin
        r_refresh_cnt <= r_refresh_cnt + 1'b1;
      end
      r_fnd_com  <= ~(4'b0001 << r_digit_idx);
      r_fnd_font <= w_font;
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_fndCom  = r_fnd_com;
  assign o_fndFont = r_fnd_font;

endmodule
